// File: rtl/alu_seq.sv
// alu_seq: multi-cycle sequencer in front of the 16-bit ALU (single ops, shift-by-N, multiply).
// Define ALU_SEQ_MUL_EN to build the 16x16 multiply (op 10); otherwise op 10 acts as reserved.
module alu_seq #(
    parameter int unsigned SHCNT_W = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [15:0] req_a,
    input  logic [15:0] req_b,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [15:0] resp_r,
    output logic        resp_z,
    output logic        resp_n,
    output logic        resp_c,
    output logic [2:0]  alu_func,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    input  logic [15:0] alu_r,
    input  logic        alu_z,
    input  logic        alu_n,
    input  logic        alu_c
);
    localparam int unsigned CNT_W = (SHCNT_W + 1 > 6) ? SHCNT_W + 1 : 6;
    localparam logic [3:0] OpShln = 4'd8;
    localparam logic [3:0] OpShrn = 4'd9;
    localparam logic [2:0] FnAdd  = 3'd0;
    localparam logic [2:0] FnShl  = 3'd3;
    localparam logic [2:0] FnShr  = 3'd4;
`ifdef ALU_SEQ_MUL_EN
    localparam logic [3:0] OpMul  = 4'd10;
`endif

    typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

    state_e             state_q, state_d;
    logic [3:0]         op_q;
    logic [15:0]        a_q, b_q;
    logic [CNT_W-1:0]   cnt_q, cnt_load;
    logic [15:0]        res_r_q;
    logic               res_z_q, res_n_q, res_c_q;
    logic               accept, last, is_alu, is_shift, kzero;
`ifdef ALU_SEQ_MUL_EN
    logic [15:0]        acc_q, mcand_q, mplier_q;
    logic               cacc_q, is_mul;

    assign is_mul = (op_q == OpMul);
`endif

    assign accept   = req_valid && req_ready;
    assign last     = (cnt_q == CNT_W'(1));
    assign is_alu   = ~op_q[3];
    assign is_shift = (op_q == OpShln) || (op_q == OpShrn);
    assign kzero    = (b_q[SHCNT_W-1:0] == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = StExec;
            StExec:  if (last) state_d = StDone;
            StDone:  if (resp_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        req_ready  = (state_q == StIdle) && rst_n;
        resp_valid = (state_q == StDone);
        resp_r     = res_r_q;
        resp_z     = res_z_q;
        resp_n     = res_n_q;
        resp_c     = res_c_q;
        alu_func   = 3'd0;
        alu_a      = 16'h0;
        alu_b      = 16'h0;
        if (state_q == StExec) begin
            if (is_alu) begin
                alu_func = op_q[2:0];
                alu_a    = a_q;
                alu_b    = b_q;
            end else if (is_shift && !kzero) begin
                alu_func = op_q[0] ? FnShr : FnShl;
                alu_a    = a_q;
            end
`ifdef ALU_SEQ_MUL_EN
            else if (is_mul) begin
                // Even count = add phase, odd count = shift phase.
                if (!cnt_q[0]) begin
                    alu_func = FnAdd;
                    alu_a    = acc_q;
                    alu_b    = mcand_q;
                end else begin
                    alu_func = FnShl;
                    alu_a    = mcand_q;
                end
            end
`endif
        end
    end

    always_comb begin
        cnt_load = CNT_W'(1);
        if ((req_op == OpShln || req_op == OpShrn) && req_b[SHCNT_W-1:0] != '0) begin
            cnt_load = CNT_W'(req_b[SHCNT_W-1:0]);
        end
`ifdef ALU_SEQ_MUL_EN
        else if (req_op == OpMul) begin
            cnt_load = CNT_W'(32);
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q    <= 4'd0;
            a_q     <= 16'h0;
            b_q     <= 16'h0;
            cnt_q   <= '0;
            res_r_q <= 16'h0;
            res_z_q <= 1'b0;
            res_n_q <= 1'b0;
            res_c_q <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            acc_q    <= 16'h0;
            mcand_q  <= 16'h0;
            mplier_q <= 16'h0;
            cacc_q   <= 1'b0;
`endif
        end else if (accept) begin
            op_q  <= req_op;
            a_q   <= req_a;
            b_q   <= req_b;
            cnt_q <= cnt_load;
`ifdef ALU_SEQ_MUL_EN
            acc_q    <= 16'h0;
            mcand_q  <= req_a;
            mplier_q <= req_b;
            cacc_q   <= 1'b0;
`endif
        end else if (state_q == StExec) begin
            cnt_q <= cnt_q - CNT_W'(1);
            if (is_alu) begin
                res_r_q <= alu_r;
                res_z_q <= alu_z;
                res_n_q <= alu_n;
                res_c_q <= alu_c;
            end else if (is_shift) begin
                if (kzero) begin
                    res_r_q <= a_q;
                    res_z_q <= (a_q == 16'h0);
                    res_n_q <= a_q[15];
                    res_c_q <= 1'b0;
                end else begin
                    a_q <= alu_r;
                    if (last) begin
                        res_r_q <= alu_r;
                        res_z_q <= alu_z;
                        res_n_q <= alu_n;
                        res_c_q <= alu_c;
                    end
                end
            end
`ifdef ALU_SEQ_MUL_EN
            else if (is_mul) begin
                if (!cnt_q[0]) begin
                    if (mplier_q[0]) begin
                        acc_q  <= alu_r;
                        cacc_q <= cacc_q | alu_c;
                    end
                end else begin
                    mcand_q  <= alu_r;
                    mplier_q <= {1'b0, mplier_q[15:1]};
                end
                // Last step is a shift phase, so acc_q already holds the product.
                if (last) begin
                    res_r_q <= acc_q;
                    res_z_q <= (acc_q == 16'h0);
                    res_n_q <= acc_q[15];
                    res_c_q <= cacc_q;
                end
            end
`endif
            else begin
                res_r_q <= 16'h0;
                res_z_q <= 1'b1;
                res_n_q <= 1'b0;
                res_c_q <= 1'b0;
            end
        end
    end
endmodule
